// File: rtl/pos_remote_output_buffer_pkg.sv
// ============================================================================
// pos_remote_output_buffer_pkg : widths shared with the position ring and the
// remote output buffer entry format.  Rev 1.0
// ============================================================================
`default_nettype none

package pos_remote_output_buffer_pkg;

  localparam int OFFSET_PKT_STRUCT_WIDTH = 24;
  localparam int GLOBAL_CELL_ID_WIDTH    = 4;
  localparam int NB_CELL_COUNT_WIDTH     = 4;
  localparam int NUM_REMOTE_DEST_NODES   = 3;

  localparam int GCID_VEC_WIDTH         = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int LIFETIME_VEC_WIDTH     = NUM_REMOTE_DEST_NODES * NB_CELL_COUNT_WIDTH;
  localparam int DEST_IDX_WIDTH         = (NUM_REMOTE_DEST_NODES > 1) ?
                                          $clog2(NUM_REMOTE_DEST_NODES) : 1;
  localparam int REMOTE_OUT_ENTRY_WIDTH = OFFSET_PKT_STRUCT_WIDTH + GCID_VEC_WIDTH +
                                          LIFETIME_VEC_WIDTH;

  typedef struct packed {
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] pkt;
    logic [GCID_VEC_WIDTH-1:0]          gcid;
    logic [LIFETIME_VEC_WIDTH-1:0]      lifetime;
  } remote_out_entry_t;

  typedef logic [NUM_REMOTE_DEST_NODES-1:0] dest_mask_t;

  // One pending bit per destination whose lifetime field is non-zero.
  function automatic dest_mask_t lifetime_to_mask(input logic [LIFETIME_VEC_WIDTH-1:0] lt);
    dest_mask_t m;
    m = '0;
    for (int d = 0; d < NUM_REMOTE_DEST_NODES; d++) begin
      m[d] = (lt[d*NB_CELL_COUNT_WIDTH +: NB_CELL_COUNT_WIDTH] != '0);
    end
    return m;
  endfunction

  function automatic logic [DEST_IDX_WIDTH-1:0] lowest_dest(input dest_mask_t m);
    logic [DEST_IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int d = NUM_REMOTE_DEST_NODES - 1; d >= 0; d--) begin
      if (m[d]) idx = DEST_IDX_WIDTH'(d);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pos_remote_out_fifo.sv
// ============================================================================
// pos_remote_out_fifo : synchronous FIFO with occupancy count and
// show-ahead read data.  Rev 1.0
// ============================================================================
`default_nettype none

module pos_remote_out_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (count_q == CNT_W'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/pos_remote_output_buffer.sv
// ============================================================================
// pos_remote_output_buffer : buffers packets diverted to remote FPGAs and
// emits one beat per destination with non-zero lifetime.  Rev 1.0
// ============================================================================
`default_nettype none

module pos_remote_output_buffer
  import pos_remote_output_buffer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_SLACK = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_offset_pkt,
  input  logic [GCID_VEC_WIDTH-1:0]          i_gcid,
  input  logic                               i_valid,
  input  logic [LIFETIME_VEC_WIDTH-1:0]      i_lifetime,
  output logic                               o_back_pressure,
  output logic [OFFSET_PKT_STRUCT_WIDTH-1:0] o_offset_pkt,
  output logic [GCID_VEC_WIDTH-1:0]          o_gcid,
  output logic [DEST_IDX_WIDTH-1:0]          o_dest_idx,
  output logic [NB_CELL_COUNT_WIDTH-1:0]     o_lifetime,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_overflow,
  output logic                               o_empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  remote_out_entry_t             w_wr_entry;
  remote_out_entry_t             w_fifo_head;
  remote_out_entry_t             head_q, head_d;
  logic                          head_valid_q, head_valid_d;
  dest_mask_t                    mask_q, mask_d;
  dest_mask_t                    w_mask_after;
  logic                          overflow_q, overflow_d;
  logic [CNT_W-1:0]              w_count;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic                          w_wr_req;
  logic                          w_fire;
  logic                          w_head_free;
  logic                          w_pop;
  logic [DEST_IDX_WIDTH-1:0]     w_dest_idx;
  logic [NB_CELL_COUNT_WIDTH-1:0] w_head_fields [NUM_REMOTE_DEST_NODES];

  assign w_wr_entry.pkt      = i_offset_pkt;
  assign w_wr_entry.gcid     = i_gcid;
  assign w_wr_entry.lifetime = i_lifetime;

  // An entry with no live destination produces no beats, so it is never stored.
  assign w_wr_req = i_valid & (i_lifetime != '0);

  pos_remote_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REMOTE_OUT_ENTRY_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_req),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  for (genvar g = 0; g < NUM_REMOTE_DEST_NODES; g++) begin : g_head_field
    assign w_head_fields[g] = head_q.lifetime[g*NB_CELL_COUNT_WIDTH +: NB_CELL_COUNT_WIDTH];
  end

  assign w_dest_idx   = lowest_dest(mask_q);
  assign o_valid      = head_valid_q & (mask_q != '0);
  assign w_fire       = o_valid & i_ready;
  assign w_mask_after = mask_q & ~(dest_mask_t'(1) << w_dest_idx);
  // The head is refillable at the same edge its last beat is accepted.
  assign w_head_free  = ~head_valid_q | (w_fire & (w_mask_after == '0));
  assign w_pop        = w_head_free & ~w_fifo_empty;

  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    mask_d       = mask_q;
    overflow_d   = overflow_q | (w_wr_req & w_fifo_full);
    if (w_fire) mask_d = w_mask_after;
    if (w_pop) begin
      head_d       = w_fifo_head;
      head_valid_d = 1'b1;
      mask_d       = lifetime_to_mask(w_fifo_head.lifetime);
    end else if (w_head_free) begin
      head_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      mask_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      mask_q       <= mask_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    o_lifetime = '0;
    for (int d = 0; d < NUM_REMOTE_DEST_NODES; d++) begin
      if (w_dest_idx == DEST_IDX_WIDTH'(d)) o_lifetime = w_head_fields[d];
    end
  end

  assign o_offset_pkt    = head_q.pkt;
  assign o_gcid          = head_q.gcid;
  assign o_dest_idx      = w_dest_idx;
  assign o_overflow      = overflow_q;
  assign o_back_pressure = (w_count >= CNT_W'(DEPTH - AF_SLACK));
  assign o_empty         = w_fifo_empty & ~head_valid_q;

endmodule

`default_nettype wire

// File: doc/pos_remote_output_buffer.md
Name: pos_remote_output_buffer

Overview:
- Sits directly downstream of the position-ring external node.
- Captures position packets the ext node diverts to remote FPGAs: offset pkt, remote-frame GCID, and the per-destination lifetime vector.
- Buffers them in a FIFO and asserts back pressure to the ext node before the FIFO overflows.
- Serializes each entry into one beat per remote destination with non-zero lifetime, toward the inter-FPGA packetizer, using a valid/ready handshake.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, ≥4).
- AF_SLACK, 2, free entries at which back pressure asserts; must be ≥2 to cover the ext node's registered write.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_offset_pkt  in  OFFSET_PKT_STRUCT_WIDTH  pkt from ext node.
- i_gcid  in  3*GLOBAL_CELL_ID_WIDTH  remote-frame GCID from ext node.
- i_valid  in  1  write strobe from ext node.
- i_lifetime  in  NUM_REMOTE_DEST_NODES*NB_CELL_COUNT_WIDTH  per-destination lifetime; field d = bits [(d+1)*W-1:d*W].
- o_back_pressure  out  1  to ext node i_remote_buffer_back_pressure.
- o_offset_pkt  out  OFFSET_PKT_STRUCT_WIDTH  beat payload.
- o_gcid  out  3*GLOBAL_CELL_ID_WIDTH  beat GCID.
- o_dest_idx  out  $clog2(NUM_REMOTE_DEST_NODES)  destination index of beat.
- o_lifetime  out  NB_CELL_COUNT_WIDTH  lifetime field for o_dest_idx.
- o_valid  out  1  beat valid.
- i_ready  in  1  packetizer accepts beat.
- o_overflow  out  1  sticky: write dropped while full.
- o_empty  out  1  FIFO and head both empty.

Behaviour:
- Reset (rst=0, async assert, sync deassert): FIFO pointers and count = 0; head invalid, dest mask = 0; all outputs 0, except o_empty=1. Reset mid-stream discards all contents; o_valid drops immediately.
- Write acceptance:
  - Write when i_valid=1 and i_lifetime≠0.
  - i_valid with all-zero lifetime is ignored: no write, no error.
  - Write when count==DEPTH is dropped and sets o_overflow, which clears only on reset.
- o_back_pressure = (count ≥ DEPTH−AF_SLACK). Combinational from the registered count only; no path from i_valid.
- Head stage: a register holding one entry plus a pending mask with bit d = (lifetime field d ≠ 0).
- Beat generation:
  - o_valid = head valid and mask≠0.
  - o_dest_idx = lowest set mask bit; o_lifetime = that field; o_offset_pkt/o_gcid = head fields.
  - Outputs are stable while o_valid=1 and i_ready=0.
- On o_valid & i_ready: clear the current mask bit. If that was the last bit, head is freed that cycle.
- Head load: when the head is invalid or freed this cycle and count>0, pop the FIFO into the head at the same edge. Back-to-back entries therefore have no bubble.
- Latency: write accepted at edge E into an empty buffer → head loaded at E+1 → o_valid=1 in the cycle after E+1 (2-cycle latency).
- Simultaneous write and pop: count unchanged; pointers both advance.
- Wrap-around: pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- o_empty = (count==0) & ~head_valid.
- Beats per entry = popcount(non-zero lifetime fields), emitted in ascending destination order.

Decomposition:
- Shared from MD_pkg: OFFSET_PKT_STRUCT_WIDTH, GLOBAL_CELL_ID_WIDTH, NB_CELL_COUNT_WIDTH, NUM_REMOTE_DEST_NODES.
- Add to MD_pkg: REMOTE_OUT_ENTRY_WIDTH (pkt + gcid + lifetime vector) and a packed struct for the entry.
- One sub-module: pos_remote_out_fifo, a sync FIFO with count, push/pop, full/empty.
- Head register, mask and priority encoder stay in the top module.

Test Plan (pkg NUM_REMOTE_DEST_NODES=3, NB_CELL_COUNT_WIDTH=4 build):
- Single entry, lifetime {d2=0, d1=5, d0=3}, i_ready=1 → beats (dest0, lt3) then (dest1, lt5) in consecutive cycles; first o_valid 2 cycles after write; o_empty returns to 1.
- Back pressure (DEPTH=16, i_ready=0): write every cycle while honoring back pressure with 1-cycle lag → o_back_pressure rises at count 14; count peaks ≤16; o_overflow stays 0.
- Forced overflow: fill to 16, then one more write ignoring back pressure → write dropped, o_overflow=1 and sticky; the 16 stored entries drain intact.
- i_ready toggling 1/0 on an entry with lifetime {1,1,1} → 3 beats; payload, dest and lifetime held stable during stalls; no dest skipped or duplicated.
- Simultaneous push/pop at count=15 with 1 mask bit left → count stays 15; pointer wrap past index 15 preserves order; i_valid with lifetime 0 is not stored.
- Assert rst mid-drain (count=5, 2 mask bits pending) → o_valid=0 immediately, o_empty=1 and o_back_pressure=0 after release; a fresh write emerges 2 cycles later.
